// File: rtl/controle_registradores.sv
// ============================================================================
// Module   : controle_registradores
// Purpose  : Command sequencer for the Y/Z register datapath. Accepts a user
//            operation and shift count on a start/busy/done handshake and
//            issues the multi-cycle LOAD / SHIFT / RESET command sequence on
//            funcY and funcZ. It is the only source of those commands.
// Ports    : clock  - system clock, rising edge
//            reset  - asynchronous, active-high reset
//            start  - request, accepted only while idle
//            op     - operation code (3 bits), latched on acceptance
//            shamt  - shift count (SHAMT_W bits), latched on acceptance
//            funcY  - command to register Y
//            funcZ  - command to register Z
//            busy   - high while an operation is in progress (FIN included)
//            done   - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_registradores #(
  parameter int         SHAMT_W = 2,
  parameter logic [2:0] HOLD    = 3'b000,
  parameter logic [2:0] LOAD    = 3'b001,
  parameter logic [2:0] SHIFTR  = 3'b010,
  parameter logic [2:0] SHIFTL  = 3'b011,
  parameter logic [2:0] RESET   = 3'b100
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [2:0]         funcY,
  output logic [2:0]         funcZ,
  output logic               busy,
  output logic               done
);

  // User operation codes
  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_LOADY     = 3'b001;
  localparam logic [2:0] OP_LOADZ     = 3'b010;
  localparam logic [2:0] OP_SHR_Z     = 3'b011;
  localparam logic [2:0] OP_SHL_Z     = 3'b100;
  localparam logic [2:0] OP_LOADZ_SHR = 3'b101;
  localparam logic [2:0] OP_CLEAR     = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LDY   = 3'd1,
    S_LDZ   = 3'd2,
    S_SHIFT = 3'd3,
    S_CLR   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  // The latched shift count lives directly in the down-counter: it is loaded
  // with shamt on acceptance and only consumed by the SHIFT state.
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = shamt;
          unique case (op)
            OP_LOADY:     state_d = S_LDY;
            OP_LOADZ:     state_d = S_LDZ;
            OP_LOADZ_SHR: state_d = S_LDZ;
            OP_CLEAR:     state_d = S_CLR;
            // A zero shift count skips SHIFT entirely so that exactly
            // shamt shift commands are issued.
            OP_SHR_Z,
            OP_SHL_Z:     state_d = (shamt != '0) ? S_SHIFT : S_FIN;
            default:      state_d = S_FIN;  // NOP and reserved code 111
          endcase
        end
      end

      S_LDY: state_d = S_FIN;

      S_LDZ: begin
        if (op_q == OP_LOADZ_SHR && cnt_q != '0) state_d = S_SHIFT;
        else                                     state_d = S_FIN;
      end

      S_SHIFT: begin
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = S_FIN;
      end

      S_CLR: state_d = S_FIN;

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Moore outputs decoded from the registered state
  // --------------------------------------------------------------------------
  always_comb begin
    funcY = HOLD;
    funcZ = HOLD;
    busy  = 1'b1;
    done  = 1'b0;

    unique case (state_q)
      S_IDLE:  busy  = 1'b0;
      S_LDY:   funcY = LOAD;
      S_LDZ:   funcZ = LOAD;
      // Only SHL_Z shifts left; SHR_Z and LOADZ_SHR both shift right.
      S_SHIFT: funcZ = (op_q == OP_SHL_Z) ? SHIFTL : SHIFTR;
      S_CLR: begin
        funcY = RESET;
        funcZ = RESET;
      end
      S_FIN:   done  = 1'b1;
      default: busy  = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_controle_registradores.sv
// ============================================================================
// Module   : tb_controle_registradores
// Purpose  : Scoreboard bench for controle_registradores. A reference model
//            expands each accepted operation into its per-cycle list of
//            expected {funcY, funcZ, busy, done} values; a monitor compares
//            every busy cycle against that list and every idle cycle against
//            the quiescent value. A small Z register model checks the
//            end-to-end effect of a command sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_registradores;

  localparam int         SHAMT_W = 2;
  localparam logic [2:0] HOLD    = 3'b000;
  localparam logic [2:0] LOAD    = 3'b001;
  localparam logic [2:0] SHIFTR  = 3'b010;
  localparam logic [2:0] SHIFTL  = 3'b011;
  localparam logic [2:0] RESET   = 3'b100;

  logic               clock;
  logic               reset;
  logic               start;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [2:0]         funcY;
  logic [2:0]         funcZ;
  logic               busy;
  logic               done;

  int n_cmp = 0;
  int n_bad = 0;

  controle_registradores #(.SHAMT_W(SHAMT_W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .shamt (shamt),
    .funcY (funcY),
    .funcZ (funcZ),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // --------------------------------------------------------------------------
  // Reference model: on acceptance, expand the operation into the expected
  // cycle-by-cycle outputs. Entry format {funcY, funcZ, busy, done}.
  // --------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         rem = 0;   // busy cycles the model still expects

  function automatic logic [7:0] ent(input logic [2:0] fy, input logic [2:0] fz,
                                     input logic d);
    return {fy, fz, 1'b1, d};
  endfunction

  task automatic model_accept(input logic [2:0] o, input int sh);
    int n;
    n = 0;
    case (o)
      3'd1: begin exp_q.push_back(ent(LOAD, HOLD, 1'b0)); n++; end
      3'd2: begin exp_q.push_back(ent(HOLD, LOAD, 1'b0)); n++; end
      3'd3: for (int i = 0; i < sh; i++) begin exp_q.push_back(ent(HOLD, SHIFTR, 1'b0)); n++; end
      3'd4: for (int i = 0; i < sh; i++) begin exp_q.push_back(ent(HOLD, SHIFTL, 1'b0)); n++; end
      3'd5: begin
        exp_q.push_back(ent(HOLD, LOAD, 1'b0)); n++;
        for (int i = 0; i < sh; i++) begin exp_q.push_back(ent(HOLD, SHIFTR, 1'b0)); n++; end
      end
      3'd6: begin exp_q.push_back(ent(RESET, RESET, 1'b0)); n++; end
      default: ;  // NOP / reserved
    endcase
    exp_q.push_back(ent(HOLD, HOLD, 1'b1)); n++;
    rem = n;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      rem = 0;
    end else if (rem > 0) begin
      rem = rem - 1;
    end else if (start) begin
      model_accept(op, int'(shamt));
    end
  end

  // Behavioural Z register driven by the DUT's commands
  logic [3:0] z_reg = 4'b0000;
  logic [3:0] z_in  = 4'b0000;
  always @(posedge clock) begin
    case (funcZ)
      LOAD:    z_reg <= z_in;
      SHIFTR:  z_reg <= z_reg >> 1;
      SHIFTL:  z_reg <= z_reg << 1;
      RESET:   z_reg <= 4'b0000;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Monitor: compares on the falling edge, away from the active edge
  // --------------------------------------------------------------------------
  always @(negedge clock) begin
    logic [7:0] act, expv;
    if (!reset) begin
      act = {funcY, funcZ, busy, done};
      if (busy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL busy_cycle: got %b but no busy cycle was expected", act);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            n_bad++;
            $display("FAIL cmd_cycle: got fy/fz/busy/done=%b required %b", act, expv);
          end
        end
      end else begin
        n_cmp++;
        if (act !== {HOLD, HOLD, 1'b0, 1'b0} || exp_q.size() != 0) begin
          n_bad++;
          $display("FAIL idle_cycle: got %b with %0d pending, required %b with 0 pending",
                   act, exp_q.size(), {HOLD, HOLD, 1'b0, 1'b0});
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (drive on the falling edge)
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_timeout: busy=%b after 20 cycles, required 0", busy);
    end
  endtask

  task automatic pulse_op(input logic [2:0] o, input logic [SHAMT_W-1:0] s);
    @(negedge clock);
    start = 1'b1;
    op    = o;
    shamt = s;
    @(negedge clock);
    start = 1'b0;
    // Post-acceptance input changes must have no effect
    op    = 3'($urandom);
    shamt = SHAMT_W'($urandom);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    shamt = '0;
    #1;
    check("reset_outputs", {funcY, funcZ, busy, done}, 8'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // LOADZ: preload Z with 1000
    z_in = 4'b1000;
    pulse_op(3'b010, 2'd0);
    wait_idle();
    @(negedge clock);
    check("z_preload", {4'b0, z_reg}, {4'b0, 4'b1000});

    // SHR_Z by 3: Z 1000 -> 0001
    pulse_op(3'b011, 2'd3);
    wait_idle();
    @(negedge clock);
    check("z_shr3", {4'b0, z_reg}, {4'b0, 4'b0001});

    // LOADZ_SHR with shamt 0 and 2
    pulse_op(3'b101, 2'd0);
    wait_idle();
    z_in = 4'b1100;
    pulse_op(3'b101, 2'd2);
    wait_idle();
    @(negedge clock);
    check("z_loadz_shr2", {4'b0, z_reg}, {4'b0, 4'b0011});

    // SHL_Z by 1, LOADY
    pulse_op(3'b100, 2'd1);
    wait_idle();
    @(negedge clock);
    check("z_shl1", {4'b0, z_reg}, {4'b0, 4'b0110});
    pulse_op(3'b001, 2'd0);
    wait_idle();

    // CLEAR with a second start issued while busy
    pulse_op(3'b110, 2'd0);
    start = 1'b1;
    op    = 3'b001;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    @(negedge clock);
    check("z_clear", {4'b0, z_reg}, 8'b0);

    // start held high with NOP: done every 2 cycles
    @(negedge clock);
    start = 1'b1;
    op    = 3'b000;
    repeat (10) @(negedge clock);
    start = 1'b0;
    wait_idle();

    // Reset asserted mid-SHIFT after one shift
    pulse_op(3'b011, 2'd3);   // now one negedge into the first SHIFT cycle
    @(posedge clock);         // first shift committed
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {funcY, funcZ, busy, done}, 8'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", {funcY, funcZ, busy, done}, 8'b0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      @(negedge clock);
      start = 1'($urandom_range(0, 1));
      op    = 3'($urandom);
      shamt = SHAMT_W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(negedge clock);
      end
    end
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
